// File: rtl/i8080_bridge_pkg.sv
// Shared definitions for the i8080-to-AHB bridge: FSM state encoding,
// default address windows and the width of the optional watchdog counter.
package i8080_bridge_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ISSUE  = 3'd1;
    localparam logic [2:0] ST_ACCEPT = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;

    // Default address windows
    localparam logic [31:0] DEFAULT_MEM_BASE = 32'h2000_0000;
    localparam logic [31:0] DEFAULT_IO_BASE  = 32'h4000_0000;

    // Width of the watchdog counter (covers TIMEOUT_CYCLES up to 65536)
    localparam int TIMEOUT_W = 16;

endpackage

// File: rtl/i8080_ahb_bridge_strobe_sync.sv
// Multi-flop synchroniser for one active-low asynchronous strobe.
// Resets to the deasserted (high) level so a reset never looks like a strobe.
module strobe_sync #(
    parameter int STAGES = 2
) (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic strobe_n,
    output logic synced_n
);

    logic [STAGES-1:0] chain;

    // Shift the raw strobe through STAGES flops, reset to the idle level
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], strobe_n};
        end
    end

    assign synced_n = chain[STAGES-1];

endmodule

// File: rtl/i8080_ahb_bridge.sv
// i8080 system-controller strobes to AHB-master request bridge.
// Turns MEMR_N/MEMW_N/IOR_N/IOW_N cycles into one-cycle READ/WRITE requests,
// stalls the CPU through CPU_READY and returns read data on CPU_D_OUT.
// Optional watchdog: define I8080_BRIDGE_TIMEOUT_EN to bound the wait for the
// AHB master and raise the sticky ERR flag on expiry.
module i8080_ahb_bridge
    import i8080_bridge_pkg::*;
#(
    parameter logic [31:0] MEM_BASE       = DEFAULT_MEM_BASE,
    parameter logic [31:0] IO_BASE        = DEFAULT_IO_BASE,
    parameter int          SYNC_STAGES    = 2,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [15:0] CPU_A,
    input  logic [7:0]  CPU_D_IN,
    output logic [7:0]  CPU_D_OUT,
    output logic        CPU_D_OE,
    input  logic        MEMR_N,
    input  logic        MEMW_N,
    input  logic        IOR_N,
    input  logic        IOW_N,
    output logic        CPU_READY,
    output logic        READ,
    output logic        WRITE,
    output logic [31:0] ADDR,
    output logic [7:0]  DATAIN,
    input  logic [7:0]  AHB_RDATA,
    input  logic        AHB_BUSY,
    input  logic        VALID,
    output logic        ERR
);

    logic [2:0]  state;
    logic        is_write;
    logic        memr_s;
    logic        memw_s;
    logic        ior_s;
    logic        iow_s;
    logic        any_sync;
    logic        any_raw;
    logic        xfer_done;
    logic        timeout_hit;
    logic [31:0] mem_addr;
    logic [31:0] io_addr;

    strobe_sync #(.STAGES(SYNC_STAGES)) u_sync_memr (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .strobe_n (MEMR_N),
        .synced_n (memr_s)
    );

    strobe_sync #(.STAGES(SYNC_STAGES)) u_sync_memw (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .strobe_n (MEMW_N),
        .synced_n (memw_s)
    );

    strobe_sync #(.STAGES(SYNC_STAGES)) u_sync_ior (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .strobe_n (IOR_N),
        .synced_n (ior_s)
    );

    strobe_sync #(.STAGES(SYNC_STAGES)) u_sync_iow (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .strobe_n (IOW_N),
        .synced_n (iow_s)
    );

    assign any_sync = ~(memr_s & memw_s & ior_s & iow_s);
    assign any_raw  = ~(MEMR_N & MEMW_N & IOR_N & IOW_N);

    // The memory window keeps the full 16-bit address, IO only the low byte
    assign mem_addr = MEM_BASE | {16'h0000, CPU_A};
    assign io_addr  = IO_BASE  | {24'h000000, CPU_A[7:0]};

    // Wait states are inserted from the raw strobe so the CPU is caught on
    // its very first T-state, before the synchronisers have seen anything
    assign CPU_READY = any_raw ? (state == ST_HOLD) : 1'b1;

    // Writes finish when the master drops BUSY, reads when data is valid
    assign xfer_done = (state == ST_WAIT) && (is_write ? !AHB_BUSY : VALID);

`ifdef I8080_BRIDGE_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_W-1:0] wd_count;

    assign timeout_hit = ((state == ST_ACCEPT) || (state == ST_WAIT)) &&
                         !xfer_done && (wd_count == TIMEOUT_LIMIT);

    // Watchdog counts only while the AHB side owns the transfer; ERR is sticky
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wd_count <= '0;
            ERR      <= 1'b0;
        end else begin
            if ((state == ST_ACCEPT) || (state == ST_WAIT)) begin
                wd_count <= wd_count + 1'b1;
            end else begin
                wd_count <= '0;
            end
            if (timeout_hit) begin
                ERR <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    // Constant 0; the limit is referenced only so it stays part of the interface
    assign ERR = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

    // Transfer sequencer: latch the request, pulse it, track the AHB side,
    // then hold the CPU bus until the strobe is withdrawn
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            is_write  <= 1'b0;
            READ      <= 1'b0;
            WRITE     <= 1'b0;
            ADDR      <= 32'h0;
            DATAIN    <= 8'h00;
            CPU_D_OUT <= 8'h00;
            CPU_D_OE  <= 1'b0;
        end else begin
            READ  <= 1'b0;
            WRITE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_sync) begin
                        state <= ST_ISSUE;
                        if (!memw_s) begin
                            ADDR     <= mem_addr;
                            DATAIN   <= CPU_D_IN;
                            is_write <= 1'b1;
                            WRITE    <= 1'b1;
                        end else if (!iow_s) begin
                            ADDR     <= io_addr;
                            DATAIN   <= CPU_D_IN;
                            is_write <= 1'b1;
                            WRITE    <= 1'b1;
                        end else if (!memr_s) begin
                            ADDR     <= mem_addr;
                            is_write <= 1'b0;
                            READ     <= 1'b1;
                        end else begin
                            ADDR     <= io_addr;
                            is_write <= 1'b0;
                            READ     <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    state <= ST_ACCEPT;
                end
                ST_ACCEPT: begin
                    if (timeout_hit) begin
                        state <= ST_HOLD;
                        if (!is_write) begin
                            CPU_D_OUT <= 8'hFF;
                            CPU_D_OE  <= 1'b1;
                        end
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (xfer_done) begin
                        if (any_sync) begin
                            state <= ST_HOLD;
                            if (!is_write) begin
                                CPU_D_OUT <= AHB_RDATA;
                                CPU_D_OE  <= 1'b1;
                            end
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (timeout_hit) begin
                        state <= ST_HOLD;
                        if (!is_write) begin
                            CPU_D_OUT <= 8'hFF;
                            CPU_D_OE  <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!any_sync) begin
                        CPU_D_OE <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i8080_ahb_bridge.sv
// Directed self-checking bench for i8080_ahb_bridge with a small AHB master
// model. The watchdog scenario runs only when I8080_BRIDGE_TIMEOUT_EN is set.
module tb_i8080_ahb_bridge;

    logic        HCLK;
    logic        HRESETn;
    logic [15:0] CPU_A;
    logic [7:0]  CPU_D_IN;
    logic [7:0]  CPU_D_OUT;
    logic        CPU_D_OE;
    logic        MEMR_N;
    logic        MEMW_N;
    logic        IOR_N;
    logic        IOW_N;
    logic        CPU_READY;
    logic        READ;
    logic        WRITE;
    logic [31:0] ADDR;
    logic [7:0]  DATAIN;
    logic [7:0]  AHB_RDATA;
    logic        AHB_BUSY;
    logic        VALID;
    logic        ERR;

    int checks = 0;
    int errors = 0;
    int read_pulses = 0;
    int write_pulses = 0;

    int       model_lat = 2;
    logic [7:0] model_rdata = 8'h00;
    logic     model_no_valid = 1'b0;
    int       busy_cnt = 0;
    logic     pend_read = 1'b0;

    i8080_ahb_bridge #(
        .TIMEOUT_CYCLES (16)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .CPU_A     (CPU_A),
        .CPU_D_IN  (CPU_D_IN),
        .CPU_D_OUT (CPU_D_OUT),
        .CPU_D_OE  (CPU_D_OE),
        .MEMR_N    (MEMR_N),
        .MEMW_N    (MEMW_N),
        .IOR_N     (IOR_N),
        .IOW_N     (IOW_N),
        .CPU_READY (CPU_READY),
        .READ      (READ),
        .WRITE     (WRITE),
        .ADDR      (ADDR),
        .DATAIN    (DATAIN),
        .AHB_RDATA (AHB_RDATA),
        .AHB_BUSY  (AHB_BUSY),
        .VALID     (VALID),
        .ERR       (ERR)
    );

    // 100 MHz clock
    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    // AHB master model: BUSY rises on the edge after a request, stays high
    // for model_lat cycles, and a read ends with a one-cycle VALID pulse
    always @(posedge HCLK) begin
        if (!HRESETn) begin
            AHB_BUSY  <= 1'b0;
            VALID     <= 1'b0;
            AHB_RDATA <= 8'h00;
            busy_cnt  <= 0;
            pend_read <= 1'b0;
        end else begin
            VALID <= 1'b0;
            if (READ || WRITE) begin
                AHB_BUSY  <= 1'b1;
                busy_cnt  <= model_lat;
                pend_read <= READ;
            end else if (AHB_BUSY) begin
                if (busy_cnt > 1) begin
                    busy_cnt <= busy_cnt - 1;
                end else begin
                    AHB_BUSY <= 1'b0;
                    if (pend_read && !model_no_valid) begin
                        VALID     <= 1'b1;
                        AHB_RDATA <= model_rdata;
                    end
                end
            end
        end
    end

    // Count request pulses independently of the checks
    always @(negedge HCLK) begin
        if (READ)  read_pulses  <= read_pulses + 1;
        if (WRITE) write_pulses <= write_pulses + 1;
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic applyStimulus(input logic memr_n, input logic memw_n,
                                 input logic ior_n, input logic iow_n,
                                 input logic [15:0] addr, input logic [7:0] data);
        CPU_A    = addr;
        CPU_D_IN = data;
        MEMR_N   = memr_n;
        MEMW_N   = memw_n;
        IOR_N    = ior_n;
        IOW_N    = iow_n;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    int  base_rd;
    int  base_wr;
    logic oe_seen;

    // Directed scenario sequence
    initial begin
        HRESETn = 1'b0;
        AHB_RDATA = 8'h00;
        applyStimulus(1, 1, 1, 1, 16'h0000, 8'h00);
        #1;
        checkOutput("rst_read",   READ,      0);
        checkOutput("rst_write",  WRITE,     0);
        checkOutput("rst_addr",   ADDR,      0);
        checkOutput("rst_datain", DATAIN,    0);
        checkOutput("rst_dout",   CPU_D_OUT, 0);
        checkOutput("rst_oe",     CPU_D_OE,  0);
        checkOutput("rst_err",    ERR,       0);
        checkOutput("rst_ready",  CPU_READY, 1);
        tick(); tick();
        HRESETn = 1'b1;
        repeat (3) tick();
        checkOutput("idle_ready", CPU_READY, 1);

        // Memory write: pulse after SYNC_STAGES+1 edges
        $display("[TB] memory write");
        model_lat = 3;
        applyStimulus(1, 0, 1, 1, 16'h1234, 8'hA5);
        #1;
        checkOutput("memw_ready_low", CPU_READY, 0);
        tick(); tick();
        checkOutput("memw_no_early", WRITE, 0);
        tick();
        checkOutput("memw_pulse",  WRITE,  1);
        checkOutput("memw_addr",   ADDR,   32'h2000_1234);
        checkOutput("memw_datain", DATAIN, 8'hA5);
        tick();
        checkOutput("memw_pulse_len", WRITE, 0);
        tick(); tick();
        checkOutput("memw_busy_ready", CPU_READY, 0);
        for (int i = 0; i < 50 && !CPU_READY; i++) tick();
        checkOutput("memw_ready_high", CPU_READY, 1);
        checkOutput("memw_oe", CPU_D_OE, 0);
        checkOutput("memw_count", write_pulses, 1);
        applyStimulus(1, 1, 1, 1, 16'h1234, 8'hA5);
        repeat (5) tick();

        // Memory read
        $display("[TB] memory read");
        model_lat = 2;
        model_rdata = 8'h3C;
        applyStimulus(0, 1, 1, 1, 16'h00FF, 8'h00);
        for (int i = 0; i < 20 && !READ; i++) tick();
        checkOutput("memr_pulse", READ, 1);
        checkOutput("memr_addr",  ADDR, 32'h2000_00FF);
        for (int i = 0; i < 50 && !CPU_READY; i++) tick();
        checkOutput("memr_ready", CPU_READY, 1);
        checkOutput("memr_dout",  CPU_D_OUT, 8'h3C);
        checkOutput("memr_oe",    CPU_D_OE,  1);
        tick(); tick();
        checkOutput("memr_oe_hold", CPU_D_OE, 1);
        applyStimulus(1, 1, 1, 1, 16'h00FF, 8'h00);
        repeat (5) tick();
        checkOutput("memr_oe_off", CPU_D_OE, 0);
        checkOutput("memr_count", read_pulses, 1);

        // IO write: upper address byte dropped
        $display("[TB] io write");
        applyStimulus(1, 1, 1, 0, 16'hAB42, 8'h5A);
        for (int i = 0; i < 20 && !WRITE; i++) tick();
        checkOutput("iow_pulse",  WRITE,  1);
        checkOutput("iow_addr",   ADDR,   32'h4000_0042);
        checkOutput("iow_datain", DATAIN, 8'h5A);
        for (int i = 0; i < 50 && !CPU_READY; i++) tick();
        checkOutput("iow_ready", CPU_READY, 1);
        applyStimulus(1, 1, 1, 1, 16'hAB42, 8'h5A);
        repeat (5) tick();

        // Back-to-back reads with a single-cycle gap
        $display("[TB] back-to-back reads");
        base_rd = read_pulses;
        model_rdata = 8'h11;
        applyStimulus(0, 1, 1, 1, 16'h0010, 8'h00);
        for (int i = 0; i < 50 && !(CPU_READY && CPU_D_OE); i++) tick();
        checkOutput("b2b_first_dout", CPU_D_OUT, 8'h11);
        model_rdata = 8'h77;
        MEMR_N = 1'b1;
        tick();
        MEMR_N = 1'b0;
        CPU_A  = 16'h0020;
        for (int i = 0; i < 20 && !READ; i++) tick();
        checkOutput("b2b_second_pulse", READ, 1);
        checkOutput("b2b_second_addr",  ADDR, 32'h2000_0020);
        for (int i = 0; i < 50 && !CPU_READY; i++) tick();
        checkOutput("b2b_second_dout", CPU_D_OUT, 8'h77);
        applyStimulus(1, 1, 1, 1, 16'h0000, 8'h00);
        repeat (6) tick();
        checkOutput("b2b_count", read_pulses - base_rd, 2);

        // Strobe withdrawn before HOLD: AHB side finishes, bus never driven
        $display("[TB] early strobe release");
        base_rd = read_pulses;
        model_lat = 3;
        applyStimulus(0, 1, 1, 1, 16'h0030, 8'h00);
        for (int i = 0; i < 20 && !READ; i++) tick();
        MEMR_N = 1'b1;
        oe_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (CPU_D_OE) oe_seen = 1'b1;
        end
        checkOutput("glitch_no_oe", oe_seen, 0);
        checkOutput("glitch_ready", CPU_READY, 1);
        checkOutput("glitch_count", read_pulses - base_rd, 1);

        // Simultaneous MEMW and MEMR: write wins, one transfer only
        $display("[TB] strobe priority");
        base_rd = read_pulses;
        base_wr = write_pulses;
        model_lat = 2;
        applyStimulus(0, 0, 1, 1, 16'h0044, 8'h99);
        for (int i = 0; i < 20 && !WRITE; i++) tick();
        checkOutput("prio_write", WRITE,  1);
        checkOutput("prio_addr",  ADDR,   32'h2000_0044);
        checkOutput("prio_data",  DATAIN, 8'h99);
        for (int i = 0; i < 50 && !CPU_READY; i++) tick();
        applyStimulus(1, 1, 1, 1, 16'h0000, 8'h00);
        repeat (6) tick();
        checkOutput("prio_wr_count", write_pulses - base_wr, 1);
        checkOutput("prio_rd_count", read_pulses - base_rd, 0);

        // Reset while a write waits on the AHB master
        $display("[TB] reset mid-transfer");
        model_lat = 20;
        applyStimulus(1, 0, 1, 1, 16'h0055, 8'h66);
        for (int i = 0; i < 20 && !WRITE; i++) tick();
        repeat (3) tick();
        HRESETn = 1'b0;
        #1;
        checkOutput("mid_rst_write", WRITE,    0);
        checkOutput("mid_rst_read",  READ,     0);
        checkOutput("mid_rst_oe",    CPU_D_OE, 0);
        checkOutput("mid_rst_addr",  ADDR,     0);
        applyStimulus(1, 1, 1, 1, 16'h0000, 8'h00);
        tick();
        HRESETn = 1'b1;
        base_rd = read_pulses;
        base_wr = write_pulses;
        repeat (10) tick();
        checkOutput("post_rst_no_wr", write_pulses - base_wr, 0);
        checkOutput("post_rst_no_rd", read_pulses - base_rd, 0);
        checkOutput("post_rst_ready", CPU_READY, 1);

`ifdef I8080_BRIDGE_TIMEOUT_EN
        // Read whose data never arrives: watchdog returns 0xFF and sets ERR
        $display("[TB] watchdog timeout");
        model_lat = 2;
        model_no_valid = 1'b1;
        applyStimulus(0, 1, 1, 1, 16'h0066, 8'h00);
        for (int i = 0; i < 60 && !CPU_READY; i++) tick();
        checkOutput("to_ready", CPU_READY, 1);
        checkOutput("to_dout",  CPU_D_OUT, 8'hFF);
        checkOutput("to_oe",    CPU_D_OE,  1);
        checkOutput("to_err",   ERR,       1);
        applyStimulus(1, 1, 1, 1, 16'h0000, 8'h00);
        model_no_valid = 1'b0;
        repeat (6) tick();
        checkOutput("to_err_sticky", ERR, 1);
        HRESETn = 1'b0;
        #1;
        checkOutput("to_err_reset", ERR, 0);
        tick();
        HRESETn = 1'b1;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
